// File: rtl/aftab_mem_byte_bridge.sv
// ---------------------------------------------------------------------------
// aftab_mem_byte_bridge
//
// Byte-wide bridge between the AFTAB data-adjustment units and a synchronous
// byte-wide external memory. One byte write or byte read is accepted per
// request. The access holds chip select for waitStates+1 cycles, then
// memReady pulses for one cycle so the adjustment unit can step its byte
// counter.
//
// State table
//   IDLE   | waiting for writeMem/readMem; latches address, data and op
//   ACCESS | memCS asserted; wait-state counter runs down to zero
//   DONE   | memReady pulse; requests are ignored for this cycle
//
// Parameters
//   size        address width in bits
//   waitStates  extra memory cycles per access (0..15)
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   writeMem       byte write request (level, sampled in IDLE only)
//   readMem        byte read request (level, sampled in IDLE only)
//   addrIn         byte address of the request
//   dataIn         write byte
//   memReady       one-cycle completion pulse
//   dataOut        last byte read; held until the next read completes
//   busy           high in ACCESS and DONE
//   collisionFlag  one-cycle pulse when write and read arrive together
//   memAddr        external memory address (latched)
//   memDataW       external write data (latched)
//   memDataR       external read data, valid on the final ACCESS cycle
//   memCS          external chip select
//   memWE          external write enable, only ever high with memCS
// ---------------------------------------------------------------------------
module aftab_mem_byte_bridge #(
  parameter int size       = 32,
  parameter int waitStates = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            writeMem,
  input  logic            readMem,
  input  logic [size-1:0] addrIn,
  input  logic [7:0]      dataIn,
  output logic            memReady,
  output logic [7:0]      dataOut,
  output logic            busy,
  output logic            collisionFlag,
  output logic [size-1:0] memAddr,
  output logic [7:0]      memDataW,
  input  logic [7:0]      memDataR,
  output logic            memCS,
  output logic            memWE
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(waitStates);

  state_t            state_q;
  logic [size-1:0]   addr_q;
  logic [7:0]        data_q;
  logic [7:0]        data_out_q;
  logic [3:0]        wait_cnt_q;
  logic              op_write_q;
  logic              mem_cs_q;
  logic              mem_we_q;
  logic              mem_ready_q;
  logic              busy_q;
  logic              collision_q;

  // All outputs come straight from flops; nothing combinational from inputs.
  // The strobes are written with their next-cycle value on each transition so
  // they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      data_out_q  <= '0;
      wait_cnt_q  <= '0;
      op_write_q  <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          mem_ready_q <= 1'b0;
          collision_q <= 1'b0;
          if (writeMem || readMem) begin
            addr_q      <= addrIn;
            data_q      <= dataIn;
            // Write wins a collision; the read is dropped, not queued.
            op_write_q  <= writeMem;
            wait_cnt_q  <= WAIT_LOAD;
            collision_q <= writeMem && readMem;
            mem_cs_q    <= 1'b1;
            mem_we_q    <= writeMem;
            busy_q      <= 1'b1;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          collision_q <= 1'b0;
          if (wait_cnt_q != 4'd0) begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end else begin
            if (!op_write_q) begin
              data_out_q <= memDataR;
            end
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_ready_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          mem_ready_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          mem_cs_q    <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_ready_q <= 1'b0;
          busy_q      <= 1'b0;
          collision_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign memReady      = mem_ready_q;
  assign dataOut       = data_out_q;
  assign busy          = busy_q;
  assign collisionFlag = collision_q;
  assign memAddr       = addr_q;
  assign memDataW      = data_q;
  assign memCS         = mem_cs_q;
  assign memWE         = mem_we_q;

endmodule
